// File: rtl/width_convert_pkg.sv
// Shared types and helpers for the round-robin front end of the width converter.
package width_convert_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Source-index width; a single requester still needs one bit to carry an index.
  function automatic int src_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_priority_pick
  import width_convert_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic               any,
  output logic [SRC_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [SRC_W:0]       off;
  logic [SRC_W:0]       sum;
  logic                 found;

  // Rotating the doubled vector right puts rr_ptr at bit 0, so a plain
  // lowest-bit encoder yields the offset from the pointer.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    any     = |req;
    off     = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_rot[i] && !found) begin
        off   = (SRC_W+1)'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, rr_ptr} + off;
    if (sum >= (SRC_W+1)'(NUM_REQ)) begin
      sum = sum - (SRC_W+1)'(NUM_REQ);
    end
    idx = sum[SRC_W-1:0];
  end

endmodule

// File: rtl/width_convert_rr_arb_rdy_val.sv
// Burst-locked round-robin arbiter feeding one width converter through a
// one-entry output register; each word is tagged with its requester index.
//
//   state      | meaning
//   ARB_IDLE   | no owner; pick next requester round-robin from rr_ptr
//   ARB_LOCKED | owner fixed until its req_last word is accepted
module width_convert_rr_arb_rdy_val
  import width_convert_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TX_DW   = 16,
  localparam int SRC_W   = src_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TX_DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_rdy,
  input  logic                     cv_rdy,
  output logic                     cv_valid,
  output logic [TX_DW-1:0]         cv_data,
  output logic [SRC_W-1:0]         cv_src,
  output logic                     cv_last,
  output logic                     grant_busy
);

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cv_valid_q, cv_valid_d;
  logic [TX_DW-1:0] cv_data_q, cv_data_d;
  logic [SRC_W-1:0] cv_src_q, cv_src_d;
  logic             cv_last_q, cv_last_d;

  logic             out_free;
  logic             pick_any;
  logic [SRC_W-1:0] pick_idx;
  logic             own_valid;
  logic             own_last;
  logic [TX_DW-1:0] own_data;
  logic             locked;
  logic             accept;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign locked   = (state_q == ARB_LOCKED);
  assign out_free = !cv_valid_q || cv_rdy;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == SRC_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*TX_DW +: TX_DW];
      end
    end
  end

  // Ready follows out_free combinationally so a draining word and a new
  // word can swap in the same cycle.
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = locked && (owner_q == SRC_W'(i)) && out_free;
    end
  end

  assign accept = locked && out_free && own_valid;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    cv_valid_d = cv_valid_q;
    cv_data_d  = cv_data_q;
    cv_src_d   = cv_src_q;
    cv_last_d  = cv_last_q;

    if (cv_valid_q && cv_rdy) begin
      cv_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept) begin
          cv_valid_d = 1'b1;
          cv_data_d  = own_data;
          cv_src_d   = owner_q;
          cv_last_d  = own_last;
          if (own_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = (owner_q == SRC_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      cv_valid_q <= 1'b0;
      cv_data_q  <= '0;
      cv_src_q   <= '0;
      cv_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      cv_valid_q <= cv_valid_d;
      cv_data_q  <= cv_data_d;
      cv_src_q   <= cv_src_d;
      cv_last_q  <= cv_last_d;
    end
  end

  assign cv_valid   = cv_valid_q;
  assign cv_data    = cv_data_q;
  assign cv_src     = cv_src_q;
  assign cv_last    = cv_last_q;
  assign grant_busy = locked;

endmodule

// File: tb/tb_width_convert_rr_arb_rdy_val.sv
// Bench for the burst-locked round-robin front end: directed scenarios plus
// random traffic checked against a transaction-level arbitration model.
module tb_width_convert_rr_arb_rdy_val;

  localparam int NUM_REQ = 4;
  localparam int TX_DW   = 16;
  localparam int SRC_W   = 2;

  logic                     clk;
  logic                     rst_b;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*TX_DW-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ-1:0]       req_rdy;
  logic                     cv_rdy;
  logic                     cv_valid;
  logic [TX_DW-1:0]         cv_data;
  logic [SRC_W-1:0]         cv_src;
  logic                     cv_last;
  logic                     grant_busy;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit               m_locked;
  int               m_owner;
  int               m_ptr;
  bit               m_cv_valid;
  logic [TX_DW-1:0] m_cv_data;
  logic [SRC_W-1:0] m_cv_src;
  bit               m_cv_last;

  width_convert_rr_arb_rdy_val #(
    .NUM_REQ (NUM_REQ),
    .TX_DW   (TX_DW)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_rdy    (req_rdy),
    .cv_rdy     (cv_rdy),
    .cv_valid   (cv_valid),
    .cv_data    (cv_data),
    .cv_src     (cv_src),
    .cv_last    (cv_last),
    .grant_busy (grant_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_REQ-1:0] exp_rdy();
    if (m_locked && (!m_cv_valid || cv_rdy)) return NUM_REQ'(1) << m_owner;
    return '0;
  endfunction

  // Advance the model one clock using the inputs currently applied.
  task automatic model_edge();
    bit ofree;
    bit acc;
    ofree = !m_cv_valid || cv_rdy;
    acc   = m_locked && ofree && req_valid[m_owner];
    if (!rst_b) begin
      m_locked = 0; m_owner = 0; m_ptr = 0;
      m_cv_valid = 0; m_cv_data = '0; m_cv_src = '0; m_cv_last = 0;
      return;
    end
    if (m_cv_valid && cv_rdy) m_cv_valid = 0;
    if (acc) begin
      m_cv_valid = 1;
      m_cv_data  = req_data[m_owner*TX_DW +: TX_DW];
      m_cv_src   = SRC_W'(m_owner);
      m_cv_last  = req_last[m_owner];
      if (req_last[m_owner]) begin
        m_locked = 0;
        m_ptr    = (m_owner + 1) % NUM_REQ;
      end
    end else if (!m_locked && req_valid != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_valid[(m_ptr + k) % NUM_REQ]) begin
          m_owner = (m_ptr + k) % NUM_REQ;
          break;
        end
      end
      m_locked = 1;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_word(input int i, input logic [TX_DW-1:0] d, input bit last, input bit v);
    req_data[i*TX_DW +: TX_DW] = d;
    req_last[i]  = last;
    req_valid[i] = v;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    cv_rdy    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_b = 1'b0;
    cyc();
    cyc();
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if ({cv_valid, cv_data, cv_src, cv_last, grant_busy, req_rdy} !== '0) begin
        bad++;
        $display("FAIL reset_idle c=%0d got=%h exp=0", c,
                 {cv_valid, cv_data, cv_src, cv_last, grant_busy, req_rdy});
      end
      cyc();
    end
    set_word(0, 16'hAAAA, 1'b0, 1'b1);
    cyc();
    cyc();
    #1;
    total++;
    if ({cv_valid, grant_busy} !== 2'b11) begin
      bad++;
      $display("FAIL reset_preburst got=%b exp=11", {cv_valid, grant_busy});
    end
    rst_b = 1'b0;
    cyc();
    #1;
    total++;
    if ({cv_valid, grant_busy, req_rdy} !== '0) begin
      bad++;
      $display("FAIL reset_midburst got=%b exp=0", {cv_valid, grant_busy, req_rdy});
    end
    rst_b = 1'b1;
    idle_inputs();
    cyc();
  endtask

  task automatic test_burst();
    do_reset();
    cv_rdy = 1'b1;
    set_word(0, 16'h1111, 1'b0, 1'b1);
    #1;
    total++;
    if (req_rdy !== 4'b0000) begin
      bad++; $display("FAIL burst_c0_rdy got=%b exp=0000", req_rdy);
    end
    cyc();
    #1;
    total++;
    if ({req_rdy, cv_valid} !== 5'b0001_0) begin
      bad++; $display("FAIL burst_c1 got=%b exp=00010", {req_rdy, cv_valid});
    end
    cyc();
    set_word(0, 16'h2222, 1'b0, 1'b1);
    #1;
    total++;
    if ({cv_valid, cv_data, cv_src, cv_last} !== {1'b1, 16'h1111, 2'd0, 1'b0}) begin
      bad++; $display("FAIL burst_w0 got=%h exp=%h", {cv_valid, cv_data, cv_src, cv_last},
                      {1'b1, 16'h1111, 2'd0, 1'b0});
    end
    cyc();
    set_word(0, 16'h3333, 1'b1, 1'b1);
    #1;
    total++;
    if ({cv_valid, cv_data, cv_src, cv_last} !== {1'b1, 16'h2222, 2'd0, 1'b0}) begin
      bad++; $display("FAIL burst_w1 got=%h exp=%h", {cv_valid, cv_data, cv_src, cv_last},
                      {1'b1, 16'h2222, 2'd0, 1'b0});
    end
    cyc();
    set_word(0, 16'h0000, 1'b0, 1'b0);
    #1;
    total++;
    if ({cv_valid, cv_data, cv_src, cv_last, grant_busy} !== {1'b1, 16'h3333, 2'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL burst_w2 got=%h exp=%h", {cv_valid, cv_data, cv_src, cv_last, grant_busy},
                      {1'b1, 16'h3333, 2'd0, 1'b1, 1'b0});
    end
    cyc();
    #1;
    total++;
    if (cv_valid !== 1'b0) begin
      bad++; $display("FAIL burst_drain got=%b exp=0", cv_valid);
    end
    set_word(0, 16'h0A0A, 1'b1, 1'b1);
    set_word(1, 16'h0B0B, 1'b1, 1'b1);
    cyc();
    #1;
    total++;
    if (req_rdy !== 4'b0010) begin
      bad++; $display("FAIL burst_rr_ptr got=%b exp=0010", req_rdy);
    end
    cyc();
    idle_inputs();
    cv_rdy = 1'b1;
    cyc();
  endtask

  task automatic test_rr_order();
    int order[$];
    int gcyc[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    cv_rdy = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_word(i, TX_DW'(16'hA000 + i), 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_rdy[i]) begin
          order.push_back(i);
          gcyc.push_back(c);
        end
      end
      cyc();
    end
    total++;
    if (order.size() != 5) begin
      bad++; $display("FAIL rr_count got=%0d exp=5", order.size());
    end
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      total++;
      if (order[k] != exp_order[k] || gcyc[k] != 2*k + 1) begin
        bad++; $display("FAIL rr_order k=%0d got=%0d@%0d exp=%0d@%0d",
                        k, order[k], gcyc[k], exp_order[k], 2*k + 1);
      end
    end
    set_word(1, 16'h0000, 1'b0, 1'b0);
    order.delete();
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_rdy[i]) order.push_back(i);
      cyc();
    end
    total++;
    if (order.size() != 1 || order[0] != 2) begin
      bad++; $display("FAIL rr_skip got_n=%0d got0=%0d exp=2", order.size(),
                      (order.size() > 0) ? order[0] : -1);
    end
  endtask

  task automatic test_wrap();
    int order[$];
    cv_rdy = 1'b1;
    for (int i = 0; i < 3; i++) set_word(i, 16'h0000, 1'b0, 1'b0);
    set_word(3, 16'hB333, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (req_valid[i] && req_rdy[i]) order.push_back(i);
      cyc();
    end
    total++;
    if (order.size() != 2 || order[0] != 3 || order[1] != 3) begin
      bad++; $display("FAIL wrap_regrant got_n=%0d exp two grants of 3", order.size());
    end
    #1;
    total++;
    if ({cv_valid, cv_src, cv_data} !== {1'b1, 2'd3, 16'hB333}) begin
      bad++; $display("FAIL wrap_src got=%h exp=%h", {cv_valid, cv_src, cv_data}, {1'b1, 2'd3, 16'hB333});
    end
    idle_inputs();
    cv_rdy = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic test_backpressure();
    int w;
    bit acc;
    logic [TX_DW-1:0] rx[$];
    do_reset();
    w = 0;
    for (int c = 0; c < 30; c++) begin
      cv_rdy = !(c >= 4 && c < 8);
      if (w < 4) set_word(2, TX_DW'(16'h5001 + w), w == 3, 1'b1);
      else       set_word(2, 16'h0000, 1'b0, 1'b0);
      #1;
      if (c >= 4 && c < 8) begin
        total++;
        if (req_rdy !== 4'b0000 || cv_valid !== 1'b1 || cv_data !== 16'h5003) begin
          bad++; $display("FAIL bp_stall c=%0d got rdy=%b v=%b d=%h exp rdy=0000 v=1 d=5003",
                          c, req_rdy, cv_valid, cv_data);
        end
      end
      if (cv_valid && cv_rdy) rx.push_back(cv_data);
      acc = req_valid[2] && req_rdy[2];
      cyc();
      if (acc) w++;
    end
    total++;
    if (rx.size() != 4) begin
      bad++; $display("FAIL bp_count got=%0d exp=4", rx.size());
    end
    for (int k = 0; k < 4 && k < rx.size(); k++) begin
      total++;
      if (rx[k] !== TX_DW'(16'h5001 + k)) begin
        bad++; $display("FAIL bp_word k=%0d got=%h exp=%h", k, rx[k], TX_DW'(16'h5001 + k));
      end
    end
    idle_inputs();
    cv_rdy = 1'b1;
    cyc();
  endtask

  task automatic test_owner_stall();
    int w;
    bit done;
    bit got2;
    bit acc0;
    bit acc2;
    do_reset();
    cv_rdy = 1'b1;
    w = 0; done = 0; got2 = 0;
    set_word(2, 16'h7777, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      set_word(0, TX_DW'(16'h6001 + w), w == 2, (w < 3) && !(c >= 3 && c < 6));
      #1;
      if (!done) begin
        total++;
        if (req_rdy[2] !== 1'b0) begin
          bad++; $display("FAIL stall_req2_rdy c=%0d got=%b exp=0", c, req_rdy[2]);
        end
      end
      acc0 = req_valid[0] && req_rdy[0];
      acc2 = req_valid[2] && req_rdy[2];
      cyc();
      if (acc0) begin
        if (w == 2) done = 1;
        w++;
      end
      if (acc2) got2 = 1;
    end
    total++;
    if (!done || !got2) begin
      bad++; $display("FAIL stall_req2_grant got done=%0d got2=%0d exp 1 1", done, got2);
    end
    idle_inputs();
    cv_rdy = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    int rem[NUM_REQ];
    bit pend[NUM_REQ];
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 0;
      pend[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      rst_b = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i]) begin
          if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
          if (rem[i] > 0 && $urandom_range(0, 3) != 0) begin
            pend[i] = 1;
            set_word(i, TX_DW'($urandom), rem[i] == 1, 1'b1);
          end else begin
            set_word(i, TX_DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
          end
        end
      end
      cv_rdy = ($urandom_range(0, 9) < 7);
      #1;
      total++;
      if (req_rdy !== exp_rdy()) begin
        bad++; $display("FAIL rnd_req_rdy c=%0d got=%b exp=%b", c, req_rdy, exp_rdy());
      end
      total++;
      if ({cv_valid, cv_data, cv_src, cv_last} !== {m_cv_valid, m_cv_data, m_cv_src, m_cv_last}) begin
        bad++; $display("FAIL rnd_cv c=%0d got=%h exp=%h", c, {cv_valid, cv_data, cv_src, cv_last},
                        {m_cv_valid, m_cv_data, m_cv_src, m_cv_last});
      end
      total++;
      if (grant_busy !== m_locked) begin
        bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, grant_busy, m_locked);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rst_b && req_valid[i] && req_rdy[i]) begin
          pend[i] = 0;
          rem[i]--;
        end
      end
      cyc();
    end
    rst_b = 1'b1;
    idle_inputs();
    cyc();
  endtask

  initial begin
    rst_b = 1'b0;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    cv_rdy = 1'b0;
    m_locked = 0; m_owner = 0; m_ptr = 0;
    m_cv_valid = 0; m_cv_data = '0; m_cv_src = '0; m_cv_last = 0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_rr_order();
    test_wrap();
    test_backpressure();
    test_owner_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/width_convert_rr_arb_rdy_val.md
Name: width_convert_rr_arb_rdy_val

Overview:
- Round-robin arbiter/scheduler that shares one hi-to-lo width converter among NUM_REQ wide-word requesters.
- Each requester sends bursts of TX_DW words on a rdy/val port, with req_last marking the end of a burst.
- Once a requester is granted, the grant locks to it until its last word is accepted, so bursts are never interleaved.
- Granted words pass through a one-entry output register to the converter's tx port. Each word is tagged with its source index.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- TX_DW, 16, wide word width; matches the converter's TX_DW.
- SRC_W, (NUM_REQ>1 ? $clog2(NUM_REQ) : 1), source-index width (derived localparam).

Ports:
- clk  input  1  clock.
- rst_b  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*TX_DW  packed data; requester i occupies [i*TX_DW +: TX_DW].
- req_last  input  NUM_REQ  per-requester end-of-burst flag, qualified by req_valid.
- req_rdy  output  NUM_REQ  per-requester ready; one-hot or zero.
- cv_rdy  input  1  converter ready (converter bx_rdy).
- cv_valid  output  1  word valid to converter (converter tx_valid).
- cv_data  output  TX_DW  word to converter.
- cv_src  output  SRC_W  requester index of cv_data.
- cv_last  output  1  last word of burst.
- grant_busy  output  1  high while the FSM is in LOCKED.

Behaviour:
Reset and transfer rules
- Only clk is used. rst_b is sampled on posedge clk; low means synchronous reset.
- Reset values: state=IDLE, owner=0, rr_ptr=0, cv_valid=0, cv_data=0, cv_src=0, cv_last=0, grant_busy=0, req_rdy=0.
- A word transfers on any cycle where valid and rdy are both high. Valid must not depend on rdy. Data and last are held while valid && !rdy.
- out_free = !cv_valid || cv_rdy.

FSM
- IDLE:
  - req_rdy = 0.
  - If |req_valid, pick the first set bit of req_valid scanning upward from rr_ptr with wrap. Register owner = that index; next state = LOCKED.
  - Otherwise stay in IDLE.
- LOCKED:
  - req_rdy[owner] = out_free; all other bits are 0.
  - On accept (req_valid[owner] && req_rdy[owner]):
    - cv_data <= the owner's slice; cv_src <= owner; cv_last <= req_last[owner]; cv_valid <= 1.
  - If the accepted word has req_last=1:
    - next state = IDLE.
    - rr_ptr <= (owner==NUM_REQ-1) ? 0 : owner+1.
  - If the owner drops valid mid-burst, the lock holds and no other requester is served. There is no timeout.

Output register
- If cv_valid && cv_rdy with no new accept in the same cycle, cv_valid <= 0.
- Simultaneous drain and accept: the register reloads and cv_valid stays 1. This gives full 1 word/cycle throughput inside a burst.

Latency and timing
- Arbitration costs one bubble cycle per burst. For req_valid first seen in IDLE at cycle 0:
  - req_rdy rises at cycle 1 (if out_free).
  - cv_valid rises at cycle 2.
- req_rdy has a combinational path from cv_rdy; this is permitted.

Boundary conditions
- NUM_REQ=1: rr_ptr stays 0, and the block degenerates to a one-word register with a 1-cycle bubble per burst.
- Single-word burst (req_last set on the first word): LOCKED lasts exactly one accepting cycle.
- A last word still pending in the output register does not block arbitration in IDLE. The next owner's first word waits via out_free.
- Reset mid-burst: the in-flight cv word is dropped, and the lock and pointer clear.
- The block does no width conversion itself; TX_DW/RX_DW divisibility is checked in the converter.

Decomposition:
- Package width_convert_pkg:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
  - function src_width(int n) returning SRC_W.
- Sub-module rr_priority_pick: combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, idx (SRC_W).
  - Implemented as a double-width rotate-and-priority-encode.
  - Instantiated once.

Test Plan:
1. Reset, then idle with all inputs low -> all outputs 0 for 10 cycles. Assert rst_b low mid-burst -> cv_valid=0 and grant_busy=0 on the next cycle.
2. Req0 sends a 3-word burst 0x1111, 0x2222, 0x3333 (last on word 3) with cv_rdy=1:
   - cv_valid rises at cycle 2.
   - Words appear on consecutive cycles with cv_src=0; cv_last=1 only on 0x3333.
   - rr_ptr then equals 1.
3. All 4 requesters valid with 1-word bursts -> grant order 0,1,2,3,0, each with one bubble. Drop req1, start from rr_ptr=1 -> order skips to 2.
4. Wrap: owner=3 finishes -> rr_ptr=0. With only req3 valid again -> req3 is re-granted.
5. Backpressure: hold cv_rdy=0 for 4 cycles mid-burst -> cv_data stable, req_rdy[owner]=0. Release -> no word lost or duplicated.
6. Owner stalls (valid=0) mid-burst while req2 is valid -> req_rdy[2] stays 0 until the owner's last word is accepted.
